// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - fetch-to-decode handshake bundle for fetch_queue
interface fetch_queue_if #(
    parameter int ADDR_WIDTH  = 32,
    parameter int INSTR_WIDTH = 32,
    parameter int CNT_WIDTH   = 3
);
    logic                   Flush;
    logic                   In_Valid;
    logic                   In_Ready;
    logic [ADDR_WIDTH-1:0]  In_PC;
    logic [INSTR_WIDTH-1:0] In_Instr;
    logic                   Out_Valid;
    logic                   Out_Ready;
    logic [ADDR_WIDTH-1:0]  Out_PC;
    logic [INSTR_WIDTH-1:0] Out_Instr;
    logic [CNT_WIDTH-1:0]   Count;
    logic                   Almost_Full;

    modport master (
        output Flush, In_Valid, In_PC, In_Instr, Out_Ready,
        input  In_Ready, Out_Valid, Out_PC, Out_Instr, Count, Almost_Full
    );

    modport slave (
        input  Flush, In_Valid, In_PC, In_Instr, Out_Ready,
        output In_Ready, Out_Valid, Out_PC, Out_Instr, Count, Almost_Full
    );
endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - DEPTH-entry {PC, instruction} queue between fetch and decode
module fetch_queue #(
    parameter int          ADDR_WIDTH   = 32,
    parameter int          INSTR_WIDTH  = 32,
    parameter int          DEPTH        = 4,
    parameter int          AFULL_THRESH = 3,
    parameter bit          BYPASS       = 1'b1,
    parameter logic [31:0] NOP_INSTR    = 32'h00000013
) (
    input  logic          clk,
    input  logic          rst,
    fetch_queue_if.slave  fq
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [CW-1:0] CNT_MAX   = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_AFULL = CW'(AFULL_THRESH);
    localparam logic [PW-1:0] PTR_LAST  = PW'(DEPTH - 1);

    logic [ADDR_WIDTH-1:0]  memPc    [DEPTH];
    logic [INSTR_WIDTH-1:0] memInstr [DEPTH];

    logic [PW-1:0] wp;
    logic [PW-1:0] rp;
    logic [CW-1:0] count;

    logic inReady;
    logic outValid;
    logic isEmpty;
    logic bypassHit;
    logic push;
    logic pop;
    logic bypassConsume;
    logic doWrite;
    logic doRead;

    logic [ADDR_WIDTH-1:0]  outPc;
    logic [INSTR_WIDTH-1:0] outInstr;

    function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PW'(1);
    endfunction

    assign isEmpty   = (count == '0);
    assign inReady   = !rst && (count < CNT_MAX);
    assign bypassHit = BYPASS && isEmpty && fq.In_Valid && inReady;
    assign outValid  = !fq.Flush && !rst && (!isEmpty || bypassHit);

    assign push = fq.In_Valid && inReady && !fq.Flush;
    assign pop  = outValid && fq.Out_Ready;

    // An empty queue only pops through the bypass path, so that pair never touches storage.
    assign bypassConsume = isEmpty && push && pop;
    assign doWrite       = push && !bypassConsume;
    assign doRead        = pop && !bypassConsume;

    always_ff @(posedge clk) begin
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else if (fq.Flush) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (doWrite) begin
                wp <= nextPtr(wp);
            end
            if (doRead) begin
                rp <= nextPtr(rp);
            end
            case ({doWrite, doRead})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is left unreset; the registered count keeps stale entries from reaching the output.
    always_ff @(posedge clk) begin
        if (doWrite) begin
            memPc[wp]    <= fq.In_PC;
            memInstr[wp] <= fq.In_Instr;
        end
    end

    always_comb begin
        outPc    = '0;
        outInstr = INSTR_WIDTH'(NOP_INSTR);
        if (outValid) begin
            if (!isEmpty) begin
                outPc    = memPc[rp];
                outInstr = memInstr[rp];
            end else begin
                outPc    = fq.In_PC;
                outInstr = fq.In_Instr;
            end
        end
    end

    assign fq.In_Ready    = inReady;
    assign fq.Out_Valid   = outValid;
    assign fq.Out_PC      = outPc;
    assign fq.Out_Instr   = outInstr;
    assign fq.Count       = count;
    assign fq.Almost_Full = !rst && (count >= CNT_AFULL);

    countBound: assert property (@(posedge clk) count <= CNT_MAX);
    popNeedsValid: assert property (@(posedge clk) disable iff (rst) pop |-> outValid);
    emptyPtrsEqual: assert property (@(posedge clk) disable iff (rst) isEmpty |-> (wp == rp));
endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed self-checking bench for fetch_queue (BYPASS=0 and BYPASS=1)
module tb_fetch_queue;
    localparam logic [31:0] NOP = 32'h00000013;

    logic clk;
    logic rst;
    int   testsRun;
    int   testsFailed;

    fetch_queue_if #(.ADDR_WIDTH(32), .INSTR_WIDTH(32), .CNT_WIDTH(3)) fq0 ();
    fetch_queue_if #(.ADDR_WIDTH(32), .INSTR_WIDTH(32), .CNT_WIDTH(3)) fq1 ();

    fetch_queue #(
        .ADDR_WIDTH(32), .INSTR_WIDTH(32), .DEPTH(4), .AFULL_THRESH(3),
        .BYPASS(1'b0), .NOP_INSTR(NOP)
    ) dut0 (
        .clk(clk),
        .rst(rst),
        .fq (fq0.slave)
    );

    fetch_queue #(
        .ADDR_WIDTH(32), .INSTR_WIDTH(32), .DEPTH(4), .AFULL_THRESH(3),
        .BYPASS(1'b1), .NOP_INSTR(NOP)
    ) dut1 (
        .clk(clk),
        .rst(rst),
        .fq (fq1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] instrOf(input logic [31:0] pc);
        return pc ^ 32'hDEAD0000;
    endfunction

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive0(input logic v, input logic [31:0] pc, input logic ordy, input logic fl);
        fq0.In_Valid  = v;
        fq0.In_PC     = pc;
        fq0.In_Instr  = instrOf(pc);
        fq0.Out_Ready = ordy;
        fq0.Flush     = fl;
    endtask

    task automatic drive1(input logic v, input logic [31:0] pc, input logic ordy, input logic fl);
        fq1.In_Valid  = v;
        fq1.In_PC     = pc;
        fq1.In_Instr  = instrOf(pc);
        fq1.Out_Ready = ordy;
        fq1.Flush     = fl;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        rst = 1'b1;
        drive0(1'b0, 32'h0, 1'b0, 1'b0);
        drive1(1'b0, 32'h0, 1'b0, 1'b0);

        // reset state
        @(negedge clk);
        checkEq("rst_in_ready0", 32'(fq0.In_Ready), 32'd0);
        checkEq("rst_out_valid0", 32'(fq0.Out_Valid), 32'd0);
        checkEq("rst_out_instr0", fq0.Out_Instr, NOP);
        checkEq("rst_afull0", 32'(fq0.Almost_Full), 32'd0);
        checkEq("rst_in_ready1", 32'(fq1.In_Ready), 32'd0);
        nextCycle();
        rst = 1'b0;
        @(negedge clk);
        checkEq("post_rst_in_ready", 32'(fq0.In_Ready), 32'd1);
        checkEq("post_rst_count", 32'(fq0.Count), 32'd0);
        checkEq("post_rst_out_pc", fq0.Out_PC, 32'd0);
        nextCycle();

        // fill to full with decode stalled
        for (int i = 0; i < 4; i++) begin
            drive0(1'b1, 32'h100 + 32'(4 * i), 1'b0, 1'b0);
            @(negedge clk);
            checkEq("fill_in_ready", 32'(fq0.In_Ready), 32'd1);
            checkEq("fill_out_valid", 32'(fq0.Out_Valid), (i == 0) ? 32'd0 : 32'd1);
            nextCycle();
            checkEq("fill_count", 32'(fq0.Count), 32'(i + 1));
            checkEq("fill_afull", 32'(fq0.Almost_Full), (i + 1 >= 3) ? 32'd1 : 32'd0);
        end
        drive0(1'b1, 32'h110, 1'b0, 1'b0);
        @(negedge clk);
        checkEq("full_in_ready", 32'(fq0.In_Ready), 32'd0);
        nextCycle();
        checkEq("full_count", 32'(fq0.Count), 32'd4);

        // drain in order
        drive0(1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkEq("drain_valid", 32'(fq0.Out_Valid), 32'd1);
            checkEq("drain_pc", fq0.Out_PC, 32'h100 + 32'(4 * i));
            checkEq("drain_instr", fq0.Out_Instr, instrOf(32'h100 + 32'(4 * i)));
            nextCycle();
        end
        @(negedge clk);
        checkEq("empty_valid", 32'(fq0.Out_Valid), 32'd0);
        checkEq("empty_instr", fq0.Out_Instr, NOP);
        checkEq("empty_pc", fq0.Out_PC, 32'd0);
        checkEq("empty_count", 32'(fq0.Count), 32'd0);
        nextCycle();

        // steady push+pop at Count=2 across pointer wrap
        drive0(1'b1, 32'h400, 1'b0, 1'b0);
        nextCycle();
        drive0(1'b1, 32'h404, 1'b0, 1'b0);
        nextCycle();
        checkEq("stream_count_start", 32'(fq0.Count), 32'd2);
        for (int i = 0; i < 10; i++) begin
            drive0(1'b1, 32'h408 + 32'(4 * i), 1'b1, 1'b0);
            @(negedge clk);
            checkEq("stream_pc", fq0.Out_PC, 32'h400 + 32'(4 * i));
            nextCycle();
            checkEq("stream_count", 32'(fq0.Count), 32'd2);
        end
        drive0(1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkEq("stream_tail_pc", fq0.Out_PC, 32'h428 + 32'(4 * i));
            nextCycle();
        end
        checkEq("stream_end_count", 32'(fq0.Count), 32'd0);

        // bypass on the BYPASS=1 instance
        drive1(1'b1, 32'h200, 1'b1, 1'b0);
        @(negedge clk);
        checkEq("byp_valid", 32'(fq1.Out_Valid), 32'd1);
        checkEq("byp_pc", fq1.Out_PC, 32'h200);
        checkEq("byp_instr", fq1.Out_Instr, instrOf(32'h200));
        nextCycle();
        checkEq("byp_count", 32'(fq1.Count), 32'd0);
        drive1(1'b1, 32'h204, 1'b0, 1'b0);
        @(negedge clk);
        checkEq("byp_stall_pc", fq1.Out_PC, 32'h204);
        nextCycle();
        checkEq("byp_stall_count", 32'(fq1.Count), 32'd1);
        drive1(1'b1, 32'h208, 1'b0, 1'b0);
        @(negedge clk);
        checkEq("byp_head_hold", fq1.Out_PC, 32'h204);
        nextCycle();
        checkEq("byp_count2", 32'(fq1.Count), 32'd2);
        drive1(1'b1, 32'h20C, 1'b1, 1'b1);
        @(negedge clk);
        checkEq("byp_flush_valid", 32'(fq1.Out_Valid), 32'd0);
        nextCycle();
        checkEq("byp_flush_count", 32'(fq1.Count), 32'd0);
        drive1(1'b1, 32'h210, 1'b1, 1'b1);
        @(negedge clk);
        checkEq("byp_empty_flush_valid", 32'(fq1.Out_Valid), 32'd0);
        nextCycle();
        drive1(1'b0, 32'h0, 1'b0, 1'b0);

        // flush at Count=3 with a concurrent push
        for (int i = 0; i < 3; i++) begin
            drive0(1'b1, 32'h500 + 32'(4 * i), 1'b0, 1'b0);
            nextCycle();
        end
        checkEq("flush_pre_count", 32'(fq0.Count), 32'd3);
        drive0(1'b1, 32'h50C, 1'b0, 1'b1);
        @(negedge clk);
        checkEq("flush_valid", 32'(fq0.Out_Valid), 32'd0);
        checkEq("flush_in_ready", 32'(fq0.In_Ready), 32'd1);
        nextCycle();
        drive0(1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        checkEq("flush_post_count", 32'(fq0.Count), 32'd0);
        checkEq("flush_post_valid", 32'(fq0.Out_Valid), 32'd0);
        nextCycle();
        drive0(1'b1, 32'h300, 1'b0, 1'b0);
        nextCycle();
        drive0(1'b0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        checkEq("flush_first_valid", 32'(fq0.Out_Valid), 32'd1);
        checkEq("flush_first_pc", fq0.Out_PC, 32'h300);
        nextCycle();
        checkEq("flush_first_count", 32'(fq0.Count), 32'd0);

        // reset mid-operation at Count=2
        drive0(1'b1, 32'h600, 1'b0, 1'b0);
        nextCycle();
        drive0(1'b1, 32'h604, 1'b0, 1'b0);
        nextCycle();
        checkEq("mid_rst_pre_count", 32'(fq0.Count), 32'd2);
        rst = 1'b1;
        drive0(1'b1, 32'h608, 1'b1, 1'b0);
        @(negedge clk);
        checkEq("mid_rst_in_ready", 32'(fq0.In_Ready), 32'd0);
        checkEq("mid_rst_valid", 32'(fq0.Out_Valid), 32'd0);
        checkEq("mid_rst_pc", fq0.Out_PC, 32'd0);
        checkEq("mid_rst_instr", fq0.Out_Instr, NOP);
        checkEq("mid_rst_afull", 32'(fq0.Almost_Full), 32'd0);
        nextCycle();
        rst = 1'b0;
        drive0(1'b0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        checkEq("after_rst_count", 32'(fq0.Count), 32'd0);
        checkEq("after_rst_in_ready", 32'(fq0.In_Ready), 32'd1);
        checkEq("after_rst_valid", 32'(fq0.Out_Valid), 32'd0);
        nextCycle();
        drive0(1'b1, 32'h700, 1'b1, 1'b0);
        @(negedge clk);
        checkEq("nobyp_valid", 32'(fq0.Out_Valid), 32'd0);
        nextCycle();
        drive0(1'b0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        checkEq("after_rst_pc", fq0.Out_PC, 32'h700);
        nextCycle();
        checkEq("after_rst_end_count", 32'(fq0.Count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised instruction queue that sits between Fetch/Icache and the IF/ID stage.
- Replaces the single stall/flush IF/ID register with a DEPTH-entry FIFO of {PC, instruction} pairs and a valid/ready handshake on both sides.
- Lets fetch keep running while decode is stalled.
- Optional same-cycle bypass when the queue is empty; flush discards every entry on a branch or exception redirect.

Parameters:
- ADDR_WIDTH, 32, PC width.
- INSTR_WIDTH, 32, instruction width.
- DEPTH, 4, number of entries; must be >=2; need not be a power of two.
- AFULL_THRESH, 3, Almost_Full asserts when Count >= AFULL_THRESH; legal range 1..DEPTH.
- BYPASS, 1, 1 = an empty queue forwards the input to the output in the same cycle; 0 = minimum one-cycle latency.
- NOP_INSTR, 32'h00000013, value driven on Out_Instr whenever Out_Valid=0.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  one clock; reset is synchronous and active-high.
- Flush  in  1  discard all entries and any same-cycle push (branch or exception redirect).
- In_Valid  in  1  fetch side presents a PC/instruction pair.
- In_Ready  out  1  queue accepts a push this cycle.
- In_PC  in  ADDR_WIDTH  PC of the pushed instruction.
- In_Instr  in  INSTR_WIDTH  pushed instruction.
- Out_Valid  out  1  head entry (or bypassed input) is valid.
- Out_Ready  in  1  decode consumes the head this cycle.
- Out_PC  out  ADDR_WIDTH  head PC; 0 when Out_Valid=0.
- Out_Instr  out  INSTR_WIDTH  head instruction; NOP_INSTR when Out_Valid=0.
- Count  out  $clog2(DEPTH+1)  number of stored entries.
- Almost_Full  out  1  Count >= AFULL_THRESH.

Behaviour:
- Storage: DEPTH-entry array; write pointer wp and read pointer rp; registered Count.
- Pointer wrap: a pointer at DEPTH-1 advances to 0 (compare-and-clear, not modulo by power of two).
- In_Ready = !rst && (Count < DEPTH). A full queue does not accept a push in a cycle where it also pops.
- push = In_Valid && In_Ready && !Flush.
- pop = Out_Valid && Out_Ready.
- Out_Valid = !Flush && !rst && ((Count != 0) || (BYPASS && In_Valid && In_Ready)).
- Output mux:
  - Count != 0: Out_PC/Out_Instr = mem[rp].
  - Count == 0 and BYPASS=1: output = In_PC/In_Instr.
  - Out_Valid == 0: output = 0 / NOP_INSTR.
- Bypass consume: Count == 0, push and pop in the same cycle → nothing is written; wp, rp and Count are unchanged.
- Bypass not consumed: Count == 0, push without pop → entry written at wp; Count becomes 1 next cycle.
- Normal update, no flush:
  - push only: mem[wp] <= input, wp advances, Count += 1.
  - pop only: rp advances, Count -= 1.
  - push and pop with Count != 0: write and read both occur, both pointers advance, Count unchanged.
- Flush has highest priority after rst:
  - Next cycle: wp = rp = 0, Count = 0.
  - Same cycle: Out_Valid forced 0, bypass included, and the input is not stored.
  - In_Ready is not forced low by Flush; fetch may drop its request itself.
- rst (synchronous):
  - Next cycle: wp = rp = Count = 0.
  - While asserted: In_Ready = 0, Out_Valid = 0, Out_PC = 0, Out_Instr = NOP_INSTR, Almost_Full = 0.
  - Reset mid-operation discards all contents.
  - Storage array contents are not reset; they are never observable, because Count gates the output.
- Latency:
  - BYPASS=1: 0 cycles when empty; otherwise, once at the head, 1 cycle after push.
  - BYPASS=0: always at least 1 cycle.
- Stability: while Out_Valid=1 and Out_Ready=0, Out_PC/Out_Instr hold stable unless Flush or rst asserts.
  - Exception: with BYPASS=1 and Count == 0, the outputs follow the input.
- Almost_Full is combinational from registered Count; fetch uses it to throttle Icache requests.
- Assertions:
  - Count never exceeds DEPTH.
  - No pop when Out_Valid=0.
  - Count == 0 implies wp == rp.

Test Plan:
- DEPTH=4, BYPASS=0: push PCs 0x100/0x104/0x108/0x10C with Out_Ready=0 → Count 1,2,3,4; Almost_Full high at Count=3; In_Ready=0 at Count=4; extra push 0x110 is not stored.
- Full queue, Out_Ready=1 for 4 cycles → Out_PC sequence 0x100,0x104,0x108,0x10C; Out_Valid low afterwards; Out_Instr=32'h00000013 when empty.
- Count=2, simultaneous push and pop for 10 cycles with incrementing PCs → Count stays 2; output order strictly FIFO across pointer wrap (wp wraps at least twice).
- BYPASS=1, empty, In_Valid=1 PC 0x200, Out_Ready=1 → Out_Valid=1 with Out_PC=0x200 in the same cycle; Count remains 0. Repeat with Out_Ready=0 → Count=1 next cycle.
- Count=3, Flush together with In_Valid=1 → Out_Valid=0 that cycle; next cycle Count=0 and Out_Valid=0; a push at 0x300 afterwards emerges first.
- rst asserted for one cycle at Count=2 → In_Ready=0 and Out_Valid=0 during rst; afterwards Count=0 and In_Ready=1; old entries are never output.
